sppf_pool_sched: RTL and testbench

- Sequencer for the shared 5x5 stride-1 padded max-pool engine in the SPPF stage.
- Runs the cascade channel by channel: pass 0 reads x and writes m5, pass 1 reads m5 and writes m9, pass 2 reads m9 and writes m13.
- After the three passes of a channel, it commits the concat (x, m5, m9, m13) for that channel.
- Sits between the layer controller (start/done) and the single pooling engine plus its buffer muxes.

---
 rtl/sppf_pool_sched_if.sv | 36 +++
 rtl/sppf_pool_sched.sv | 134 +++++++++++++
 tb/tb_sppf_pool_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sppf_pool_sched_if.sv
// Handshake bundle between the SPPF pool sequencer, the layer controller
// and the shared 5x5 max-pool engine with its buffer muxes.
interface sppf_pool_sched_if #(
   parameter int CH_W = 8
);
   // Layer controller side
   logic            start;
   logic [CH_W-1:0] cfg_ch;
   logic            abort;
   logic            busy;
   logic            done;
   logic            err;
   // Pool engine side
   logic            eng_start;
   logic            eng_done;
   logic [1:0]      eng_src_sel;
   logic [1:0]      eng_dst_sel;
   logic [CH_W-1:0] eng_ch;
   // Concat buffer side
   logic            cat_wr_en;
   logic [CH_W-1:0] cat_ch;

   // Requester / engine model: drives commands and completions
   modport master (
      output start, cfg_ch, abort, eng_done,
      input  busy, done, err, eng_start, eng_src_sel, eng_dst_sel, eng_ch,
             cat_wr_en, cat_ch
   );

   // Sequencer
   modport slave (
      input  start, cfg_ch, abort, eng_done,
      output busy, done, err, eng_start, eng_src_sel, eng_dst_sel, eng_ch,
             cat_wr_en, cat_ch
   );
endinterface

// File: rtl/sppf_pool_sched.sv
// SPPF pool sequencer: per channel, runs the x->m5, m5->m9, m9->m13 pool
// cascade on the shared engine, then commits the (x, m5, m9, m13) concat.
module sppf_pool_sched #(
   parameter int CH_W   = 8,
   parameter int MAX_CH = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   sppf_pool_sched_if.slave     bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAT,
      S_DONE
   } state_t;

   localparam logic [CH_W:0] MAX_WIDE = (CH_W+1)'(MAX_CH);

   state_t          state;
   logic [CH_W-1:0] cnt;
   logic [CH_W-1:0] ch;
   logic [1:0]      pass;

   logic [CH_W:0]   cfg_wide;
   logic [CH_W-1:0] cfg_clamped;

   // Clamp the requested channel count to the largest legal value.
   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      cfg_wide    = {1'b0, bus.cfg_ch};
      cfg_clamped = bus.cfg_ch;
      if (cfg_wide > MAX_WIDE) cfg_clamped = MAX_WIDE[CH_W-1:0];
   end

   // Sequencer FSM; every output is registered alongside the state.
   // NOTE: sequential state uses non-blocking assignments only, so all
   // registers update together from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: only a handful of control registers, so all of them are reset.
      if (!reset) begin
         state           <= S_IDLE;
         cnt             <= '0;
         ch              <= '0;
         pass            <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
         bus.eng_start   <= 1'b0;
         bus.eng_src_sel <= 2'd0;
         bus.eng_dst_sel <= 2'd0;
         bus.eng_ch      <= '0;
         bus.cat_wr_en   <= 1'b0;
         bus.cat_ch      <= '0;
      end else begin
         // Pulses last one cycle unless re-armed below
         bus.eng_start <= 1'b0;
         bus.cat_wr_en <= 1'b0;
         bus.done      <= 1'b0;

         if (bus.abort && (state != S_IDLE)) begin
            // Abort wins over eng_done and start; selects keep their last value
            state    <= S_IDLE;
            cnt      <= '0;
            ch       <= '0;
            pass     <= '0;
            bus.busy <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     cnt      <= cfg_clamped;
                     ch       <= '0;
                     pass     <= '0;
                     bus.err  <= 1'b0;
                     bus.busy <= 1'b1;
                     if (cfg_clamped == '0) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                     end else begin
                        state           <= S_ISSUE;
                        bus.eng_start   <= 1'b1;
                        bus.eng_src_sel <= 2'd0;
                        bus.eng_dst_sel <= 2'd0;
                        bus.eng_ch      <= '0;
                     end
                  end
               end
               S_ISSUE: state <= S_WAIT;
               S_WAIT: begin
                  if (bus.eng_done) begin
                     if (pass != 2'd2) begin
                        pass            <= pass + 2'd1;
                        state           <= S_ISSUE;
                        bus.eng_start   <= 1'b1;
                        bus.eng_src_sel <= pass + 2'd1;
                        bus.eng_dst_sel <= pass + 2'd1;
                     end else begin
                        state         <= S_CAT;
                        bus.cat_wr_en <= 1'b1;
                        bus.cat_ch    <= ch;
                     end
                  end
               end
               S_CAT: begin
                  if (ch == cnt - CH_W'(1)) begin
                     state    <= S_DONE;
                     bus.done <= 1'b1;
                  end else begin
                     ch              <= ch + CH_W'(1);
                     pass            <= 2'd0;
                     state           <= S_ISSUE;
                     bus.eng_start   <= 1'b1;
                     bus.eng_src_sel <= 2'd0;
                     bus.eng_dst_sel <= 2'd0;
                     bus.eng_ch      <= ch + CH_W'(1);
                  end
               end
               S_DONE: begin
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end

         // A completion outside WAIT is a protocol error; it overrides a start clear
         if (bus.eng_done && (state != S_WAIT)) bus.err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sppf_pool_sched.sv
// Directed bench for the SPPF pool sequencer with a fixed-latency engine model.
// Cycle t of a job is the t-th clock period after the one in which start is sampled.
module tb_sppf_pool_sched;

   localparam int CH_W = 8;

   logic clk;
   logic reset;

   sppf_pool_sched_if #(.CH_W(CH_W)) bus ();

   sppf_pool_sched #(.CH_W(CH_W), .MAX_CH(255)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks = 0;
   int   failures = 0;
   int   lat = 1;
   int   pend = 0;
   logic model_done = 1'b0;
   logic spur_done = 1'b0;

   assign bus.eng_done = model_done | spur_done;

   // Job trace
   int   es_cyc[$], es_src[$], es_dst[$], es_ch[$];
   int   cw_cyc[$], cw_ch[$];
   int   done_cyc, done_cnt, busy_first, busy_last, overlap;
   logic busy_log[0:127];
   logic err_log[0:127];
   int   src_log[0:127];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine model: eng_done exactly lat cycles after eng_start
   always @(negedge clk) begin
      model_done = 1'b0;
      if (!reset) pend = 0;
      else begin
         if (pend > 0) begin
            pend--;
            if (pend == 0) model_done = 1'b1;
         end
         if (bus.eng_start) pend = lat;
      end
   end

   // Issue start with cfg in cycle 0 and trace ncyc cycles
   task automatic run_job(input int cfg, input int l, input int ncyc,
                          input int abort_at, input int spur_at, input int restart_at);
      es_cyc.delete(); es_src.delete(); es_dst.delete(); es_ch.delete();
      cw_cyc.delete(); cw_ch.delete();
      done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; overlap = 0;
      for (int i = 0; i < 128; i++) begin
         busy_log[i] = 1'b0; err_log[i] = 1'b0; src_log[i] = 0;
      end
      lat = l;
      bus.cfg_ch = CH_W'(cfg);
      bus.start  = 1'b1;
      for (int t = 1; t <= ncyc; t++) begin
         @(negedge clk);
         if (bus.eng_start) begin
            es_cyc.push_back(t);
            es_src.push_back(int'(bus.eng_src_sel));
            es_dst.push_back(int'(bus.eng_dst_sel));
            es_ch.push_back(int'(bus.eng_ch));
         end
         if (bus.cat_wr_en) begin
            cw_cyc.push_back(t);
            cw_ch.push_back(int'(bus.cat_ch));
         end
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = t;
         end
         if (bus.busy) begin
            if (busy_first < 0) busy_first = t;
            busy_last = t;
         end
         if (bus.eng_start && bus.cat_wr_en) overlap++;
         busy_log[t] = bus.busy;
         err_log[t]  = bus.err;
         src_log[t]  = int'(bus.eng_src_sel);
         // cfg only matters at an accepted start; change it to expose late sampling
         bus.cfg_ch = '0;
         bus.start  = (t == restart_at);
         bus.abort  = (t == abort_at);
         spur_done  = (t == spur_at);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      spur_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_ch = '0;
      @(negedge clk); @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      checks++; if ({bus.eng_start, bus.cat_wr_en} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b expected 00", {bus.eng_start, bus.cat_wr_en}); end
      checks++; if ({bus.eng_src_sel, bus.eng_dst_sel, bus.eng_ch, bus.cat_ch} !== '0) begin failures++; $display("FAIL reset_sel_ch: got %h expected 0", {bus.eng_src_sel, bus.eng_dst_sel, bus.eng_ch, bus.cat_ch}); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      run_job(1, 1, 12, -1, -1, -1);
      checks++; if (es_cyc.size() !== 3) begin failures++; $display("FAIL single_es_count: got %0d expected 3", es_cyc.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (es_cyc[i] !== 1 + 2*i) begin failures++; $display("FAIL single_es_cyc%0d: got %0d expected %0d", i, es_cyc[i], 1 + 2*i); end
         checks++; if (es_src[i] !== i || es_dst[i] !== i) begin failures++; $display("FAIL single_sel%0d: got src %0d dst %0d expected %0d", i, es_src[i], es_dst[i], i); end
      end
      checks++; if (cw_cyc.size() !== 1 || cw_cyc[0] !== 7 || cw_ch[0] !== 0) begin failures++; $display("FAIL single_cat: got n=%0d cyc=%0d ch=%0d expected n=1 cyc=7 ch=0", cw_cyc.size(), cw_cyc[0], cw_ch[0]); end
      checks++; if (done_cyc !== 8 || done_cnt !== 1) begin failures++; $display("FAIL single_done: got cyc=%0d n=%0d expected cyc=8 n=1", done_cyc, done_cnt); end
      checks++; if (busy_first !== 1 || busy_last !== 8) begin failures++; $display("FAIL single_busy: got %0d..%0d expected 1..8", busy_first, busy_last); end
      checks++; if (overlap !== 0) begin failures++; $display("FAIL single_overlap: got %0d expected 0", overlap); end
   endtask

   task automatic test_three_ch();
      run_job(3, 4, 55, -1, -1, -1);
      checks++; if (done_cyc !== 49) begin failures++; $display("FAIL three_done_cyc: got %0d expected 49", done_cyc); end
      checks++; if (es_cyc.size() !== 9) begin failures++; $display("FAIL three_es_count: got %0d expected 9", es_cyc.size()); end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (es_cyc[i] !== 1 + (i/3)*16 + (i%3)*5 || es_ch[i] !== i/3 || es_src[i] !== i%3 || es_dst[i] !== i%3) begin
            failures++;
            $display("FAIL three_es%0d: got cyc=%0d ch=%0d src=%0d dst=%0d expected cyc=%0d ch=%0d sel=%0d",
                     i, es_cyc[i], es_ch[i], es_src[i], es_dst[i], 1 + (i/3)*16 + (i%3)*5, i/3, i%3);
         end
      end
      checks++; if (cw_cyc.size() !== 3) begin failures++; $display("FAIL three_cat_count: got %0d expected 3", cw_cyc.size()); end
      for (int c = 0; c < 3; c++) begin
         checks++; if (cw_cyc[c] !== 16 + 16*c || cw_ch[c] !== c) begin failures++; $display("FAIL three_cat%0d: got cyc=%0d ch=%0d expected cyc=%0d ch=%0d", c, cw_cyc[c], cw_ch[c], 16 + 16*c, c); end
      end
      checks++; if (overlap !== 0) begin failures++; $display("FAIL three_overlap: got %0d expected 0", overlap); end
   endtask

   task automatic test_zero_ch();
      run_job(0, 1, 4, -1, -1, -1);
      checks++; if (done_cyc !== 1 || done_cnt !== 1) begin failures++; $display("FAIL zero_done: got cyc=%0d n=%0d expected cyc=1 n=1", done_cyc, done_cnt); end
      checks++; if (es_cyc.size() !== 0 || cw_cyc.size() !== 0) begin failures++; $display("FAIL zero_activity: got es=%0d cat=%0d expected 0 0", es_cyc.size(), cw_cyc.size()); end
      checks++; if (busy_first !== 1 || busy_last !== 1) begin failures++; $display("FAIL zero_busy: got %0d..%0d expected 1..1", busy_first, busy_last); end
   endtask

   task automatic test_abort();
      // cfg=2, L=3: channel 1 pass 1 issues at 18 and waits 19..21
      run_job(2, 3, 24, 19, -1, -1);
      checks++; if (busy_log[19] !== 1'b1 || busy_log[20] !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b%b expected 10", busy_log[19], busy_log[20]); end
      checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
      checks++; if (es_cyc.size() !== 5) begin failures++; $display("FAIL abort_es_count: got %0d expected 5", es_cyc.size()); end
      checks++; if (src_log[20] !== 1) begin failures++; $display("FAIL abort_sel_hold: got %0d expected 1", src_log[20]); end
      checks++; if (err_log[21] !== 1'b0 || err_log[22] !== 1'b1) begin failures++; $display("FAIL abort_late_done_err: got %b%b expected 01", err_log[21], err_log[22]); end
      run_job(1, 3, 16, -1, -1, -1);
      checks++; if (es_cyc[0] !== 1 || es_ch[0] !== 0 || es_src[0] !== 0) begin failures++; $display("FAIL abort_restart: got cyc=%0d ch=%0d src=%0d expected 1 0 0", es_cyc[0], es_ch[0], es_src[0]); end
      checks++; if (err_log[1] !== 1'b0) begin failures++; $display("FAIL abort_err_clear: got %b expected 0", err_log[1]); end
      checks++; if (done_cyc !== 14) begin failures++; $display("FAIL abort_restart_done: got %0d expected 14", done_cyc); end
   endtask

   task automatic test_spurious();
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL spur_pre_err: got %b expected 0", bus.err); end
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL spur_idle: got err=%b busy=%b expected 1 0", bus.err, bus.busy); end
      // Spurious completion while in ISSUE (cycle 1), L=2
      run_job(1, 2, 14, -1, 1, -1);
      checks++; if (err_log[1] !== 1'b0 || err_log[2] !== 1'b1) begin failures++; $display("FAIL spur_issue_err: got %b%b expected 01", err_log[1], err_log[2]); end
      checks++; if (busy_log[2] !== 1'b1 || es_cyc.size() !== 3) begin failures++; $display("FAIL spur_issue_flow: got busy=%b es=%0d expected 1 3", busy_log[2], es_cyc.size()); end
      checks++; if (done_cyc !== 11 || err_log[11] !== 1'b1) begin failures++; $display("FAIL spur_issue_done: got cyc=%0d err=%b expected 11 1", done_cyc, err_log[11]); end
   endtask

   task automatic test_busy_start_and_reset();
      // cfg=2, L=3; start again at cycle 3 (WAIT) with cfg_ch=0
      run_job(2, 3, 7, -1, -1, 3);
      checks++; if (es_cyc.size() !== 2 || es_cyc[1] !== 5 || es_src[1] !== 1 || es_ch[1] !== 0) begin failures++; $display("FAIL busy_start_ignored: got n=%0d cyc=%0d src=%0d ch=%0d expected 2 5 1 0", es_cyc.size(), es_cyc[1], es_src[1], es_ch[1]); end
      checks++; if (done_cnt !== 0 || busy_log[4] !== 1'b1) begin failures++; $display("FAIL busy_start_state: got done=%0d busy=%b expected 0 1", done_cnt, busy_log[4]); end
      // Async reset in the middle of WAIT
      reset = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.eng_src_sel !== 2'd0 || bus.eng_dst_sel !== 2'd0) begin failures++; $display("FAIL async_reset: got busy=%b src=%0d dst=%0d expected 0 0 0", bus.busy, bus.eng_src_sel, bus.eng_dst_sel); end
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      run_job(1, 1, 12, -1, -1, -1);
      checks++; if (done_cyc !== 8 || es_cyc.size() !== 3 || err_log[8] !== 1'b0) begin failures++; $display("FAIL reset_resume: got done=%0d es=%0d err=%b expected 8 3 0", done_cyc, es_cyc.size(), err_log[8]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_three_ch();
      test_zero_ch();
      test_abort();
      test_spurious();
      test_busy_start_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
